// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the five-stage pipeline. Latches the
//               EX->MEM bus, runs loads/stores over a req/ack data-memory
//               port, stalls the pipeline while an access is outstanding and
//               drives the MEM->WB bus plus MEM-stage forwarding info.
//               Optional macro MEM_TIMEOUT_EN adds an ACCESS watchdog that
//               abandons an access after TIMEOUT_CYCLES cycles without ack
//               and raises the sticky mem_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [104:0]  ex_to_mem_bus,
  input  logic          flushM,
  input  logic          bubbleM,
  output logic [102:0]  mem_to_wb_bus,
  output logic          stall_mem,
  output logic [4:0]    reg_dest_mem,
  output logic          reg_w_en_mem,
  output logic [31:0]   mem_fwd_data,
  output logic          dm_req,
  output logic          dm_we,
  output logic [31:0]   dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata,
  input  logic          dm_ack,
  output logic          mem_err
);

  // --------------------------------------------------------------------------
  // Parameter sanity: the watchdog counter is 8 bits wide.
  // --------------------------------------------------------------------------
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Stage register and control state
  logic [104:0] r_q, r_d;
  state_t       state_q, state_d;
  logic         kill_q, kill_d;
  logic [31:0]  rdata_q, rdata_d;

  // Stage-register fields (EX->MEM layout, MSB first)
  logic [31:0]  r_pc;
  logic [4:0]   r_wb_addr;
  logic [31:0]  r_alu_out;
  logic [31:0]  r_store_data;
  logic         r_mem_read;
  logic         r_mem_write;
  logic         r_mem_to_reg;
  logic         r_wb_en;

  assign r_pc         = r_q[104:73];
  assign r_wb_addr    = r_q[72:68];
  assign r_alu_out    = r_q[67:36];
  assign r_store_data = r_q[35:4];
  assign r_mem_read   = r_q[3];
  assign r_mem_write  = r_q[2];
  assign r_mem_to_reg = r_q[1];
  assign r_wb_en      = r_q[0];

  // Incoming instruction needs the memory port
  logic ex_is_mem;
  assign ex_is_mem = ex_to_mem_bus[3] | ex_to_mem_bus[2];

  logic in_access;
  logic acked;
  logic timeout;
  logic discard;
  logic upd;
  logic enter_access;
  logic [31:0] load_data;

  assign in_access = (state_q == ST_ACCESS);
  assign acked     = in_access && dm_ack;

  // The stage only stalls while an access is still waiting for its ack;
  // a watchdog expiry frees the pipeline in the same cycle.
  assign stall_mem = in_access && !dm_ack && !timeout;

  // A killed access completing, or an abandoned one, leaves nothing for WB.
  assign discard = (acked && kill_q) || timeout;

  // The stage register updates whenever the stage is not stalled and either
  // the hazard unit lets it advance or a flush clears it (flush beats bubble).
  assign upd = !stall_mem && (flushM || !bubbleM);

  // A fresh memory instruction is captured this cycle (restarts the watchdog)
  assign enter_access = upd && !flushM && ex_is_mem;

  // Load data: bypassed from the port in the ack cycle, replayed from the
  // capture register while parked in DONE, zero otherwise and for stores.
  always_comb begin
    load_data = 32'd0;
    if (r_mem_read) begin
      if (acked) begin
        load_data = dm_rdata;
      end else if (state_q == ST_DONE) begin
        load_data = rdata_q;
      end
    end
  end

  // Memory port: address/data come straight from the stage register, so they
  // cannot move while the access is outstanding.
  assign dm_req   = in_access && !timeout;
  assign dm_we    = dm_req && r_mem_write;
  assign dm_addr  = {r_alu_out[31:2], 2'b00};
  assign dm_wdata = r_store_data;

  // MEM->WB bus: a bubble while stalled or when the result is dropped
  assign mem_to_wb_bus = (stall_mem || discard) ? 103'd0 :
                         {r_pc, r_wb_addr, load_data, r_alu_out,
                          r_mem_to_reg, r_wb_en};

  // Forwarding view of the instruction currently in MEM
  assign reg_dest_mem = r_wb_addr;
  assign reg_w_en_mem = r_wb_en && !stall_mem && !discard;
  assign mem_fwd_data = r_mem_to_reg ? load_data : r_alu_out;

  // Next-state logic for the stage register, FSM, kill flag and load buffer
  always_comb begin
    r_d     = r_q;
    state_d = state_q;
    kill_d  = kill_q;
    rdata_d = rdata_q;

    if (acked) begin
      rdata_d = dm_rdata;
      kill_d  = 1'b0;
      if (kill_q) begin
        // Flushed while in flight: throw the completed access away
        r_d     = 105'd0;
        state_d = ST_IDLE;
      end else begin
        // Completed but possibly unable to advance: park in DONE so the
        // access is never reissued
        state_d = ST_DONE;
      end
    end else if (timeout) begin
      r_d     = 105'd0;
      state_d = ST_IDLE;
      kill_d  = 1'b0;
    end else if (in_access && flushM) begin
      // The port cannot abort an access; remember to drop it on ack
      kill_d = 1'b1;
    end

    // A capture (or flush) overrides the completion bookkeeping above so the
    // instruction the hazard unit advances out of EX is never lost.
    if (upd) begin
      kill_d = 1'b0;
      if (flushM) begin
        r_d     = 105'd0;
        state_d = ST_IDLE;
      end else begin
        r_d     = ex_to_mem_bus;
        state_d = ex_is_mem ? ST_ACCESS : ST_IDLE;
      end
    end
  end

  // Stage register, FSM state, kill flag and load buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= 105'd0;
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      r_q     <= r_d;
      state_q <= state_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] c_timeout_cnt = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  // cnt_q holds the number of ACCESS cycles already spent without ack, so the
  // request is visible for exactly TIMEOUT_CYCLES cycles before abandonment.
  assign timeout = in_access && !dm_ack && (cnt_q == c_timeout_cnt);
  assign mem_err = mem_err_q;

  // Watchdog counter and sticky error next-state
  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q | timeout;
    if (enter_access) begin
      cnt_d = 8'd0;
    end else if (in_access && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
`else
  logic unused_enter_access;

  assign timeout             = 1'b0;
  assign mem_err             = 1'b0;
  assign unused_enter_access = enter_access;
`endif

endmodule
`default_nettype wire
